col2im_2d_stream: RTL and testbench

// - Inverse of the im2col stage: accepts im2col columns (one KxK patch per column, raster patch order) over a valid/ready stream.
// - Overlap-adds every patch element into an internal IMAGE_HEIGHT x IMAGE_WIDTH accumulator buffer.
// - Streams the reconstructed map out row-major. Used for transposed-conv / gradient fold-back and as a golden inverse for im2col checks.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/col2im_addr_gen.sv | 27 ++
 rtl/col2im_2d_stream.sv | 159 +++++++++++++++
 tb/tb_col2im_2d_stream.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and geometry helpers for the im2col / col2im convolution stages.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } col2im_state_t;

  // Number of patch positions along one axis of a padded, strided sweep.
  function automatic int num_positions(input int dim, input int k, input int s, input int p);
    return (dim - k + 2 * p) / s + 1;
  endfunction

  // Accumulator wide enough for K*K full-scale elements landing on one pixel.
  function automatic int acc_width(input int dw, input int k);
    return dw + $clog2(k * k + 1);
  endfunction

endpackage

// File: rtl/col2im_addr_gen.sv
// Maps one patch tap at patch position (hpos, vpos) onto an image pixel,
// flagging taps that fall into the zero border.
module col2im_addr_gen #(
  parameter int IMAGE_WIDTH  = 4,
  parameter int IMAGE_HEIGHT = 4,
  parameter int KERNEL_SIZE  = 2,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 0,
  parameter int HPOS_W       = 2,
  parameter int VPOS_W       = 2
) (
  input  logic [HPOS_W-1:0] hpos,
  input  logic [VPOS_W-1:0] vpos,
  input  int                tap,
  output int                row,
  output int                col,
  output logic              in_bounds
);

  // Signed arithmetic so padded taps come out negative rather than wrapping.
  assign row = int'(vpos) * STRIDE + tap / KERNEL_SIZE - PADDING;
  assign col = int'(hpos) * STRIDE + tap % KERNEL_SIZE - PADDING;

  assign in_bounds = (row >= 0) && (row < IMAGE_HEIGHT) &&
                     (col >= 0) && (col < IMAGE_WIDTH);

endmodule

// File: rtl/col2im_2d_stream.sv
// Column-to-image fold: overlap-adds streamed KxK patches into an HxW buffer,
// then drains the reconstructed map row-major over a valid/ready stream.
module col2im_2d_stream
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 4,
  parameter int IMAGE_HEIGHT = 4,
  parameter int KERNEL_SIZE  = 2,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 0,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              start,
  input  logic                                              col_valid,
  output logic                                              col_ready,
  input  logic [0:KERNEL_SIZE*KERNEL_SIZE-1][DATA_WIDTH-1:0] col_data,
  output logic                                              pix_valid,
  input  logic                                              pix_ready,
  output logic [acc_width(DATA_WIDTH, KERNEL_SIZE)-1:0]      pix_data,
  output logic                                              pix_last,
  output logic                                              busy,
  output logic                                              done
);

  localparam int KK        = KERNEL_SIZE * KERNEL_SIZE;
  localparam int HPOS      = num_positions(IMAGE_WIDTH, KERNEL_SIZE, STRIDE, PADDING);
  localparam int VPOS      = num_positions(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE, PADDING);
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, KERNEL_SIZE);
  localparam int HPOS_W    = (HPOS > 1) ? $clog2(HPOS) : 1;
  localparam int VPOS_W    = (VPOS > 1) ? $clog2(VPOS) : 1;
  localparam int ROW_W     = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int COL_W     = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

  col2im_state_t state, state_nxt;

  logic [HPOS_W-1:0]    hpos;
  logic [VPOS_W-1:0]    vpos;
  logic [ROW_W-1:0]     pix_r;
  logic [COL_W-1:0]     pix_c;
  logic [ACC_WIDTH-1:0] acc_buf [IMAGE_HEIGHT][IMAGE_WIDTH];
  logic [ACC_WIDTH-1:0] pix_add [IMAGE_HEIGHT][IMAGE_WIDTH];
  int                   tap_row [KK];
  int                   tap_col [KK];
  logic                 tap_in  [KK];
  logic                 frame_start, col_hs, pix_hs, last_col, at_last_pix, done_q;

  assign frame_start = (state == IDLE) && start;
  assign col_hs      = col_valid && col_ready;
  assign pix_hs      = pix_valid && pix_ready;
  assign last_col    = (hpos == HPOS_W'(HPOS - 1)) && (vpos == VPOS_W'(VPOS - 1));
  assign at_last_pix = (pix_r == ROW_W'(IMAGE_HEIGHT - 1)) && (pix_c == COL_W'(IMAGE_WIDTH - 1));

  for (genvar t = 0; t < KK; t++) begin : g_tap
    col2im_addr_gen #(
      .IMAGE_WIDTH (IMAGE_WIDTH),
      .IMAGE_HEIGHT(IMAGE_HEIGHT),
      .KERNEL_SIZE (KERNEL_SIZE),
      .STRIDE      (STRIDE),
      .PADDING     (PADDING),
      .HPOS_W      (HPOS_W),
      .VPOS_W      (VPOS_W)
    ) u_addr (
      .hpos     (hpos),
      .vpos     (vpos),
      .tap      (t),
      .row      (tap_row[t]),
      .col      (tap_col[t]),
      .in_bounds(tap_in[t])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    col_ready = 1'b0;
    pix_valid = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = ACCUM;
      ACCUM: begin
        col_ready = 1'b1;
        if (col_valid && last_col) state_nxt = DRAIN;
      end
      DRAIN: begin
        pix_valid = 1'b1;
        if (pix_ready && at_last_pix) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A single patch never hits the same pixel twice, so OR-merging the taps is exact.
  always_comb begin
    for (int r = 0; r < IMAGE_HEIGHT; r++) begin
      for (int c = 0; c < IMAGE_WIDTH; c++) begin
        pix_add[r][c] = '0;
        for (int t = 0; t < KK; t++) begin
          if (tap_in[t] && tap_row[t] == r && tap_col[t] == c)
            pix_add[r][c] = pix_add[r][c] | ACC_WIDTH'(col_data[t]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < IMAGE_HEIGHT; r++) begin
      for (int c = 0; c < IMAGE_WIDTH; c++) begin
        if (!rst_n || frame_start) acc_buf[r][c] <= '0;
        else if (col_hs)           acc_buf[r][c] <= acc_buf[r][c] + pix_add[r][c];
      end
    end
  end

  // Patch position and drain raster counters; both wrap to zero after a full frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos   <= '0;
      vpos   <= '0;
      pix_r  <= '0;
      pix_c  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= pix_hs && at_last_pix;
      if (frame_start) begin
        hpos  <= '0;
        vpos  <= '0;
        pix_r <= '0;
        pix_c <= '0;
      end
      if (col_hs) begin
        if (hpos == HPOS_W'(HPOS - 1)) begin
          hpos <= '0;
          vpos <= (vpos == VPOS_W'(VPOS - 1)) ? '0 : vpos + 1'b1;
        end else begin
          hpos <= hpos + 1'b1;
        end
      end
      if (pix_hs) begin
        if (pix_c == COL_W'(IMAGE_WIDTH - 1)) begin
          pix_c <= '0;
          pix_r <= (pix_r == ROW_W'(IMAGE_HEIGHT - 1)) ? '0 : pix_r + 1'b1;
        end else begin
          pix_c <= pix_c + 1'b1;
        end
      end
    end
  end

  assign pix_data = (state == DRAIN) ? acc_buf[pix_r][pix_c] : '0;
  assign pix_last = (state == DRAIN) && at_last_pix;
  assign busy     = (state != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_col2im_2d_stream.sv
// Directed bench for col2im_2d_stream: three geometries on a 4x4 image of 1..16,
// checked against hand-computed fold-back tables.
module tb_col2im_2d_stream;

  localparam int W = 4;
  localparam int H = 4;
  localparam int K_OF    [3] = '{2, 2, 3};
  localparam int S_OF    [3] = '{1, 2, 1};
  localparam int P_OF    [3] = '{0, 0, 1};
  localparam int NCOL_OF [3] = '{9, 4, 16};
  localparam int T1_EXP [16] = '{1, 4, 6, 4, 10, 24, 28, 16, 18, 40, 44, 24, 13, 28, 30, 16};
  localparam int T3_EXP [16] = '{4, 12, 18, 16, 30, 54, 63, 48, 54, 90, 99, 72, 52, 84, 90, 64};

  typedef struct {
    int id;
    int dut;
    bit gaps;
    bit toggle;
    bit poke;
  } run_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_v = '0;
  logic [2:0] colv_v = '0;
  logic [2:0] prdy_v = '0;
  logic [2:0] crdy_v, pval_v, plast_v, busy_v, done_v;
  logic [7:0] cb [9];
  logic [10:0] pd0, pd1;
  logic [11:0] pd2;

  int checks = 0;
  int passed = 0;
  int got_data [16];
  int got_last [16];
  run_t runs [5];

  always #5 clk = ~clk;

  col2im_2d_stream #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .KERNEL_SIZE(2), .STRIDE(1),
                     .PADDING(0), .DATA_WIDTH(8)) dut_k2s1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .col_valid(colv_v[0]), .col_ready(crdy_v[0]),
    .col_data({cb[0], cb[1], cb[2], cb[3]}), .pix_valid(pval_v[0]), .pix_ready(prdy_v[0]),
    .pix_data(pd0), .pix_last(plast_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  col2im_2d_stream #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .KERNEL_SIZE(2), .STRIDE(2),
                     .PADDING(0), .DATA_WIDTH(8)) dut_k2s2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .col_valid(colv_v[1]), .col_ready(crdy_v[1]),
    .col_data({cb[0], cb[1], cb[2], cb[3]}), .pix_valid(pval_v[1]), .pix_ready(prdy_v[1]),
    .pix_data(pd1), .pix_last(plast_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  col2im_2d_stream #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .KERNEL_SIZE(3), .STRIDE(1),
                     .PADDING(1), .DATA_WIDTH(8)) dut_k3p1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .col_valid(colv_v[2]), .col_ready(crdy_v[2]),
    .col_data({cb[0], cb[1], cb[2], cb[3], cb[4], cb[5], cb[6], cb[7], cb[8]}),
    .pix_valid(pval_v[2]), .pix_ready(prdy_v[2]),
    .pix_data(pd2), .pix_last(plast_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  function automatic int get_pd(input int d);
    case (d)
      0:       return int'(pd0);
      1:       return int'(pd1);
      default: return int'(pd2);
    endcase
  endfunction

  function automatic int exp_pix(input int d, input int i);
    case (d)
      0:       return T1_EXP[i];
      1:       return i + 1;
      default: return T3_EXP[i];
    endcase
  endfunction

  // im2col element of the source image 1..16; padded taps carry junk the DUT must drop.
  function automatic logic [7:0] col_elem(input int d, input int col, input int e);
    int k, s, p, hn, r, c;
    k  = K_OF[d];
    s  = S_OF[d];
    p  = P_OF[d];
    hn = (W - k + 2 * p) / s + 1;
    r  = (col / hn) * s + e / k - p;
    c  = (col % hn) * s + e % k - p;
    if (r < 0 || r >= H || c < 0 || c >= W) return 8'hEE;
    return 8'(r * W + c + 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int got, input int expv);
    checks++;
    if (got == expv) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expv);
  endtask

  task automatic loadColumn(input int d, input int col);
    for (int e = 0; e < 9; e++)
      cb[e] = (e < K_OF[d] * K_OF[d]) ? col_elem(d, col, e) : 8'h00;
  endtask

  // Full frame: start, feed every column, drain all pixels, then confirm the done pulse.
  task automatic applyStimulus(input int d, input bit gaps, input bit toggle, input bit poke);
    int sent, n, budget, held_data, held_last;
    bit v, rdy, hs, holding;
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    checkOutput("busy after start", int'(busy_v[d]), 1);
    sent = 0;
    budget = 0;
    while (sent < NCOL_OF[d] && budget < 500) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (v) loadColumn(d, sent);
      colv_v[d] = v;
      if (poke && sent == 2) start_v[d] = 1'b1;
      hs = v && crdy_v[d];
      tick();
      budget++;
      start_v[d] = 1'b0;
      if (hs) sent++;
    end
    colv_v[d] = 1'b0;
    checkOutput("columns accepted", sent, NCOL_OF[d]);
    checkOutput("pix_valid after last column", int'(pval_v[d]), 1);
    n = 0;
    budget = 0;
    holding = 1'b0;
    held_data = 0;
    held_last = 0;
    while (n < 16 && budget < 500) begin
      rdy = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      prdy_v[d] = rdy;
      if (poke && n == 5) start_v[d] = 1'b1;
      if (pval_v[d]) begin
        if (holding) begin
          checkOutput("stalled pix_data", get_pd(d), held_data);
          checkOutput("stalled pix_last", int'(plast_v[d]), held_last);
        end
        if (rdy) begin
          got_data[n] = get_pd(d);
          got_last[n] = int'(plast_v[d]);
          n++;
          holding = 1'b0;
        end else begin
          held_data = get_pd(d);
          held_last = int'(plast_v[d]);
          holding = 1'b1;
        end
      end
      tick();
      budget++;
      start_v[d] = 1'b0;
    end
    prdy_v[d] = 1'b0;
    checkOutput("pixels drained", n, 16);
    checkOutput("done pulse", int'(done_v[d]), 1);
    checkOutput("busy after drain", int'(busy_v[d]), 0);
    tick();
    checkOutput("done single cycle", int'(done_v[d]), 0);
  endtask

  task automatic checkFrame(input int id, input int d);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("T%0d pix%0d data", id, i), got_data[i], exp_pix(d, i));
      checkOutput($sformatf("T%0d pix%0d last", id, i), got_last[i], (i == 15) ? 1 : 0);
    end
  endtask

  initial begin
    for (int e = 0; e < 9; e++) cb[e] = 8'h00;
    runs[0] = '{1, 0, 1'b0, 1'b0, 1'b0};
    runs[1] = '{2, 1, 1'b0, 1'b0, 1'b0};
    runs[2] = '{3, 2, 1'b0, 1'b0, 1'b0};
    runs[3] = '{4, 0, 1'b1, 1'b1, 1'b0};
    runs[4] = '{6, 0, 1'b0, 1'b0, 1'b1};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      checkOutput("reset busy", int'(busy_v[d]), 0);
      checkOutput("reset col_ready", int'(crdy_v[d]), 0);
      checkOutput("reset pix_valid", int'(pval_v[d]), 0);
      checkOutput("reset done", int'(done_v[d]), 0);
    end

    // Columns offered while idle are not accepted.
    colv_v[0] = 1'b1;
    tick();
    checkOutput("idle col_ready", int'(crdy_v[0]), 0);
    checkOutput("idle busy", int'(busy_v[0]), 0);
    colv_v[0] = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(runs[i].dut, runs[i].gaps, runs[i].toggle, runs[i].poke);
      checkFrame(runs[i].id, runs[i].dut);
    end

    // Abort after five columns, then a clean frame must show no residue.
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      loadColumn(0, c);
      colv_v[0] = 1'b1;
      tick();
    end
    colv_v[0] = 1'b0;
    checkOutput("T5 busy before abort", int'(busy_v[0]), 1);
    rst_n = 1'b0;
    tick();
    checkOutput("T5 abort busy", int'(busy_v[0]), 0);
    checkOutput("T5 abort col_ready", int'(crdy_v[0]), 0);
    checkOutput("T5 abort pix_valid", int'(pval_v[0]), 0);
    checkOutput("T5 abort pix_last", int'(plast_v[0]), 0);
    checkOutput("T5 abort pix_data", get_pd(0), 0);
    checkOutput("T5 abort done", int'(done_v[0]), 0);
    rst_n = 1'b1;
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkFrame(5, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
